dram_store_serializer: RTL and testbench

Downstream neighbour of the scratchpad DRAM-store FSM. It accepts one full-row store request (`sStore`, `store_addr`, `store_data`) and breaks the row into bus-width beats. It issues those beats to the DRAM write port over a valid/ready handshake, then returns a one-cycle `sStore_hit` once the last beat is accepted. The block sits between the scratchpad store path and the memory-side write bus, and holds exactly one row in flight.

---
 rtl/sp_types_pkg.sv | 14 +
 rtl/dram_store_serializer_if.sv | 41 ++++
 rtl/dram_store_perf.sv | 27 ++
 rtl/dram_store_serializer.sv | 122 ++++++++++++
 tb/tb_dram_store_serializer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sp_types_pkg.sv
// Shared scratchpad types and widths used by the DRAM store path.
package sp_types_pkg;

  localparam int unsigned BITS_PER_ROW = 256;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned DRAM_BEAT_W  = 64;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_BURST,
    SER_DONE
  } dram_ser_state_t;

endpackage

// File: rtl/dram_store_serializer_if.sv
// Bundle of the dram_store_serializer ports; DRAM_STORE_PERF_EN adds the perf counters.
interface dram_store_serializer_if
  import sp_types_pkg::*;
#(
  parameter int unsigned ROW_W  = BITS_PER_ROW,
  parameter int unsigned BEAT_W = DRAM_BEAT_W,
  parameter int unsigned ADDR_W = WORD_W
) ();

  logic              sStore;
  logic [ADDR_W-1:0] store_addr;
  logic [ROW_W-1:0]  store_data;
  logic              sStore_hit;
  logic              busy;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic              mem_last;
  logic              mem_ready;
`ifdef DRAM_STORE_PERF_EN
  logic [31:0]       perf_rows;
  logic [31:0]       perf_stalls;
`endif

  modport ser (
    input  sStore, store_addr, store_data, mem_ready,
    output sStore_hit, busy, mem_wen, mem_addr, mem_wdata, mem_last
`ifdef DRAM_STORE_PERF_EN
    , output perf_rows, perf_stalls
`endif
  );

  modport tb (
    output sStore, store_addr, store_data, mem_ready,
    input  sStore_hit, busy, mem_wen, mem_addr, mem_wdata, mem_last
`ifdef DRAM_STORE_PERF_EN
    , input perf_rows, perf_stalls
`endif
  );

endinterface

// File: rtl/dram_store_perf.sv
// Saturating row and stall counters for the DRAM store serializer.
module dram_store_perf (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_row_done,
  input  logic        i_stall,
  output logic [31:0] o_rows,
  output logic [31:0] o_stalls
);

  logic [31:0] r_rows;
  logic [31:0] r_stalls;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rows   <= '0;
      r_stalls <= '0;
    end else begin
      if (i_row_done && (r_rows != '1)) r_rows <= r_rows + 32'd1;
      if (i_stall && (r_stalls != '1)) r_stalls <= r_stalls + 32'd1;
    end
  end

  assign o_rows   = r_rows;
  assign o_stalls = r_stalls;

endmodule

// File: rtl/dram_store_serializer.sv
// Splits one scratchpad row into DRAM write beats over a valid/ready handshake.
// Defining DRAM_STORE_PERF_EN adds the perf_rows / perf_stalls counter outputs.
module dram_store_serializer
  import sp_types_pkg::*;
#(
  parameter int unsigned ROW_W  = BITS_PER_ROW,
  parameter int unsigned BEAT_W = DRAM_BEAT_W,
  parameter int unsigned ADDR_W = WORD_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              sStore,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [ROW_W-1:0]  store_data,
  output logic              sStore_hit,
  output logic              busy,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  output logic              mem_last,
  input  logic              mem_ready
`ifdef DRAM_STORE_PERF_EN
  ,
  output logic [31:0]       perf_rows,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int unsigned       NBEATS     = ROW_W / BEAT_W;
  localparam int unsigned       IDX_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned       ALIGN_W    = $clog2(ROW_W / 8);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NBEATS - 1);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BEAT_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_W) - ADDR_W'(1));

  if ((ROW_W % BEAT_W) != 0) begin : g_bad_cfg
    $error("ROW_W must be a multiple of BEAT_W");
  end

  dram_ser_state_t   r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic              r_last;
  logic              r_hit;

  logic              w_accept;
  logic [IDX_W-1:0]  w_idx_nxt;

  assign w_accept  = r_wen & mem_ready;
  assign w_idx_nxt = r_idx + IDX_W'(1);

  // r_row shifts down one beat per handshake, so its low bits are always the current beat.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= SER_IDLE;
      r_idx   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_last  <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      unique case (r_state)
        SER_IDLE: begin
          r_hit <= 1'b0;
          if (sStore) begin
            r_row   <= store_data;
            r_addr  <= store_addr & ALIGN_MASK;
            r_idx   <= '0;
            r_wen   <= 1'b1;
            r_last  <= (NBEATS == 1);
            r_state <= SER_BURST;
          end
        end
        SER_BURST: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_wen   <= 1'b0;
              r_last  <= 1'b0;
              r_hit   <= 1'b1;
              r_state <= SER_DONE;
            end else begin
              r_idx  <= w_idx_nxt;
              r_row  <= r_row >> BEAT_W;
              r_addr <= r_addr + BEAT_BYTES;
              r_last <= (w_idx_nxt == LAST_IDX);
            end
          end
        end
        SER_DONE: begin
          r_hit   <= 1'b0;
          r_state <= SER_IDLE;
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end

  assign sStore_hit = r_hit;
  assign busy       = (r_state != SER_IDLE);
  assign mem_wen    = r_wen;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_row[BEAT_W-1:0];
  assign mem_last   = r_last;

`ifdef DRAM_STORE_PERF_EN
  logic w_stall;
  assign w_stall = (r_state == SER_BURST) & r_wen & ~mem_ready;

  dram_store_perf u_perf (
    .i_clk      (CLK),
    .i_rst_n    (nRST),
    .i_row_done (r_hit),
    .i_stall    (w_stall),
    .o_rows     (perf_rows),
    .o_stalls   (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_dram_store_serializer.sv
// Self-checking bench for dram_store_serializer (ROW_W=256, BEAT_W=64, ADDR_W=16).
module tb_dram_store_serializer;

  localparam int unsigned ROW_W  = 256;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned ADDR_W = 16;
  localparam int          NB     = ROW_W / BEAT_W;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              sStore = 1'b0;
  logic [ADDR_W-1:0] store_addr = '0;
  logic [ROW_W-1:0]  store_data = '0;
  logic              sStore_hit;
  logic              busy;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic              mem_last;
  logic              mem_ready = 1'b0;
`ifdef DRAM_STORE_PERF_EN
  logic [31:0]       perf_rows;
  logic [31:0]       perf_stalls;
`endif

  dram_store_serializer #(
    .ROW_W  (ROW_W),
    .BEAT_W (BEAT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .sStore     (sStore),
    .store_addr (store_addr),
    .store_data (store_data),
    .sStore_hit (sStore_hit),
    .busy       (busy),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_last   (mem_last),
    .mem_ready  (mem_ready)
`ifdef DRAM_STORE_PERF_EN
    ,
    .perf_rows   (perf_rows),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ROW_W-1:0]  data;
    logic [ADDR_W-1:0] base;
    int                stall_beat;
    int                stall_len;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rnd_row();
    logic [ROW_W-1:0] v;
    for (int i = 0; i < ROW_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " hit"}, sStore_hit, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " wen"}, mem_wen, 0);
    chk({tag, " last"}, mem_last, 0);
    chk({tag, " addr"}, mem_addr, 0);
    chk({tag, " wdata"}, mem_wdata, 0);
  endtask

  // Drive one row and check every beat against the row split into NB slices at base + 8k.
  task automatic do_row(input logic [ADDR_W-1:0] addr, input logic [ROW_W-1:0] data,
                        input logic [ADDR_W-1:0] base, input int stall_beat, input int stall_len,
                        input bit rnd_stall, input bit perturb, input string tag);
    int cyc, k, stalls, left;
    bit rdy;
    logic [ADDR_W-1:0] ea;
`ifdef DRAM_STORE_PERF_EN
    logic [31:0] s0, r0;
`endif
    cyc = 0; k = 0; stalls = 0; left = stall_len;
    @(negedge CLK);
    sStore = 1'b1; store_addr = addr; store_data = data; mem_ready = 1'b1;
`ifdef DRAM_STORE_PERF_EN
    s0 = perf_stalls; r0 = perf_rows;
`endif
    @(posedge CLK);
    while (k < NB && cyc < 64) begin
      @(negedge CLK);
      cyc++;
      if (perturb) begin
        sStore = 1'($urandom); store_addr = ADDR_W'($urandom); store_data = rnd_row();
      end else begin
        sStore = 1'b0;
      end
      ea = base + ADDR_W'(k * (BEAT_W / 8));
      chk({tag, " wen"}, mem_wen, 1);
      chk({tag, " addr"}, mem_addr, ea);
      chk({tag, " wdata"}, mem_wdata, data[k*BEAT_W +: BEAT_W]);
      chk({tag, " last"}, mem_last, (k == NB - 1));
      chk({tag, " busy"}, busy, 1);
      chk({tag, " early hit"}, sStore_hit, 0);
      if (rnd_stall) rdy = ($urandom_range(0, 3) != 0);
      else if (k == stall_beat && left > 0) begin rdy = 1'b0; left--; end
      else rdy = 1'b1;
      mem_ready = rdy;
      if (rdy) k++; else stalls++;
    end
    if (k < NB) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: beats %0d of %0d", tag, k, NB);
    end
    @(negedge CLK);
    sStore = 1'b0; mem_ready = 1'b1;
    chk({tag, " hit"}, sStore_hit, 1);
    chk({tag, " done wen"}, mem_wen, 0);
    chk({tag, " done busy"}, busy, 1);
`ifdef DRAM_STORE_PERF_EN
    chk({tag, " perf_stalls"}, perf_stalls - s0, 32'(stalls));
`endif
    @(negedge CLK);
    chk({tag, " hit drop"}, sStore_hit, 0);
    chk({tag, " idle busy"}, busy, 0);
`ifdef DRAM_STORE_PERF_EN
    chk({tag, " perf_rows"}, perf_rows - r0, 1);
`endif
  endtask

  initial begin
    logic [ROW_W-1:0] d_ref;
    logic [ADDR_W-1:0] ra;
    int t1, t2, nhits, guard;

    d_ref = {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
             64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
    tbl[0] = '{addr: 16'h1000, data: d_ref, base: 16'h1000, stall_beat: -1, stall_len: 0};
    tbl[1] = '{addr: 16'h1000, data: d_ref, base: 16'h1000, stall_beat: 2, stall_len: 3};
    tbl[2] = '{addr: 16'h1013, data: d_ref, base: 16'h1000, stall_beat: -1, stall_len: 0};
    tbl[3] = '{addr: 16'hFFE0, data: d_ref, base: 16'hFFE0, stall_beat: -1, stall_len: 0};

    #12;
    chk_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 4; i++) do_row(tbl[i].addr, tbl[i].data, tbl[i].base,
                                       tbl[i].stall_beat, tbl[i].stall_len, 1'b0, 1'b0,
                                       $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      ra = ADDR_W'($urandom);
      do_row(ra, rnd_row(), ra & 16'hFFE0, -1, 0, 1'b1, 1'b0, $sformatf("rnd%0d", i));
    end

    do_row(16'h4020, rnd_row(), 16'h4020, -1, 0, 1'b1, 1'b1, "perturb");

    // Reset while beat 1 is presented
    @(negedge CLK);
    sStore = 1'b1; store_addr = 16'h3000; store_data = rnd_row(); mem_ready = 1'b1;
    @(negedge CLK);
    sStore = 1'b0;
    chk("rst beat0 addr", mem_addr, 16'h3000);
    @(negedge CLK);
    chk("rst beat1 addr", mem_addr, 16'h3008);
    mem_ready = 1'b0;
    #2 nRST = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge CLK);
    nRST = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("post-rst no hit", sStore_hit, 0);
      chk("post-rst idle", busy, 0);
    end
    do_row(16'h5000, rnd_row(), 16'h5000, -1, 0, 1'b0, 1'b0, "after-rst");

    // Back-to-back rows with sStore held high through IDLE
    @(negedge CLK);
    sStore = 1'b1; store_addr = 16'h2000; store_data = rnd_row(); mem_ready = 1'b1;
    nhits = 0; t1 = 0; t2 = 0; guard = 0;
    while (nhits < 2 && guard < 40) begin
      @(negedge CLK);
      guard++;
      if (sStore_hit) begin
        nhits++;
        if (nhits == 1) t1 = guard; else t2 = guard;
        if (nhits == 2) sStore = 1'b0;
      end
    end
    chk("b2b hit count", nhits, 2);
    chk("b2b spacing", t2 - t1, 6);
    chk("b2b first hit", t1, 5);
    repeat (3) @(negedge CLK);
    chk("b2b drained", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
